control_unit: RTL and testbench

Hard-wired Mini SRC control sequencer that sits directly upstream of the datapath. It decodes IR_Data and drives every datapath control strobe, one T-step per clock, for fetch and execute. It replaces the hand-timed stimulus processes now used to exercise the datapath.

---
 rtl/control_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: hard-wired Mini SRC control sequencer.
// Decodes IR_Data and drives the datapath control strobes, one T-step per clock,
// through fetch (T0-T2) and execute (T3-T7).
// Optional mul/div sequencing is enabled by defining CU_MULDIV_EN; without it
// opcodes 15/16 behave as nop.
module control_unit #(
   parameter int         FETCH_STEPS = 3,
   parameter logic [4:0] ADD_CODE    = 5'b00011
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR_Data,
   input  logic        CON_out,
   input  logic        Stop,
   output logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
   output logic        OutPort_in, IncPC, CON_in,
   output logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out,
   output logic        InPort_out, C_out,
   output logic        Read, Write,
   output logic        Gra, Grb, Grc, Rin, Rout, BAout,
   output logic [4:0]  alu_instruction_bits,
   output logic [15:0] RX_in_man,
   output logic        Run
);

`ifdef CU_MULDIV_EN
   localparam bit MULDIV_EN = 1'b1;
`else
   localparam bit MULDIV_EN = 1'b0;
`endif

   typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

   localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2;
   localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14;
   localparam logic [4:0] OP_DIV = 5'd15, OP_MUL = 5'd16, OP_NEG = 5'd17, OP_NOT = 5'd18;
   localparam logic [4:0] OP_BR = 5'd19, OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22;
   localparam logic [4:0] OP_OUT = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_HALT = 5'd27;

   localparam logic [26:0] M_PC_IN      = 27'd1 << 0;
   localparam logic [26:0] M_IR_IN      = 27'd1 << 1;
   localparam logic [26:0] M_Y_IN       = 27'd1 << 2;
   localparam logic [26:0] M_Z_IN       = 27'd1 << 3;
   localparam logic [26:0] M_HI_IN      = 27'd1 << 4;
   localparam logic [26:0] M_LO_IN      = 27'd1 << 5;
   localparam logic [26:0] M_MAR_IN     = 27'd1 << 6;
   localparam logic [26:0] M_MDR_IN     = 27'd1 << 7;
   localparam logic [26:0] M_OUTPORT_IN = 27'd1 << 8;
   localparam logic [26:0] M_INCPC      = 27'd1 << 9;
   localparam logic [26:0] M_CON_IN     = 27'd1 << 10;
   localparam logic [26:0] M_PC_OUT     = 27'd1 << 11;
   localparam logic [26:0] M_ZHIGH_OUT  = 27'd1 << 12;
   localparam logic [26:0] M_ZLOW_OUT   = 27'd1 << 13;
   localparam logic [26:0] M_HI_OUT     = 27'd1 << 14;
   localparam logic [26:0] M_LO_OUT     = 27'd1 << 15;
   localparam logic [26:0] M_MDR_OUT    = 27'd1 << 16;
   localparam logic [26:0] M_INPORT_OUT = 27'd1 << 17;
   localparam logic [26:0] M_C_OUT      = 27'd1 << 18;
   localparam logic [26:0] M_READ       = 27'd1 << 19;
   localparam logic [26:0] M_WRITE      = 27'd1 << 20;
   localparam logic [26:0] M_GRA        = 27'd1 << 21;
   localparam logic [26:0] M_GRB        = 27'd1 << 22;
   localparam logic [26:0] M_GRC        = 27'd1 << 23;
   localparam logic [26:0] M_RIN        = 27'd1 << 24;
   localparam logic [26:0] M_ROUT       = 27'd1 << 25;
   localparam logic [26:0] M_BAOUT      = 27'd1 << 26;

   state_t       state_q, state_d;
   logic [4:0]   op_q, op_d;
   logic [26:0]  strb_q, strb_d;
   logic [4:0]   alu_q, alu_d;
   logic [15:0]  rx_q, rx_d;
   logic         run_q, run_d;
   logic         unused_ir;

   assign unused_ir = ^IR_Data[26:0];

   // Final execute step of each instruction class; the step after it is T0
   function automatic state_t last_step(input logic [4:0] op);
      if (op == OP_LD || op == OP_ST)                   return T7;
      else if (op == OP_BR)                             return T6;
      else if (op == OP_LDI || (op >= 5'd3 && op <= OP_ORI)) return T5;
      else if (MULDIV_EN && (op == OP_DIV || op == OP_MUL))  return T6;
      else if (op == OP_NEG || op == OP_NOT || op == OP_JAL) return T4;
      else                                              return T3;
   endfunction

   // Next-state selection and Moore decode of the strobes for the state being entered
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      strb_d  = '0;
      alu_d   = '0;
      rx_d    = '0;
      case (state_q)
         RESET:  state_d = T0;
         T0:     state_d = T1;
         T1:     state_d = T2;
         T2: begin
            state_d = T3;
            op_d    = IR_Data[31:27];
         end
         T3, T4, T5, T6, T7: begin
            if (state_q == last_step(op_q))
               state_d = (op_q == OP_HALT) ? HALT : T0;
            else
               state_d = state_t'(state_q + 4'd1);
         end
         default: state_d = HALT;
      endcase
      if (state_d == T0 && Stop)
         state_d = HALT;
      run_d = (state_d != HALT);

      case (state_d)
         T0: strb_d = M_PC_OUT | M_MAR_IN | M_INCPC | M_Z_IN;
         T1: strb_d = M_ZLOW_OUT | M_PC_IN | M_READ | M_MDR_IN;
         T2: strb_d = M_MDR_OUT | M_IR_IN;
         T3, T4, T5, T6, T7: begin
            if (op_d == OP_LD || op_d == OP_LDI || op_d == OP_ST) begin
               case (state_d)
                  T3: strb_d = M_GRB | M_BAOUT | M_Y_IN;
                  T4: begin
                     strb_d = M_C_OUT | M_Z_IN;
                     alu_d  = ADD_CODE;
                  end
                  T5: strb_d = (op_d == OP_LDI) ? (M_ZLOW_OUT | M_GRA | M_RIN)
                                                : (M_ZLOW_OUT | M_MAR_IN);
                  T6: strb_d = (op_d == OP_LD) ? (M_READ | M_MDR_IN)
                                               : (M_GRA | M_ROUT | M_MDR_IN);
                  T7: strb_d = (op_d == OP_LD) ? (M_MDR_OUT | M_GRA | M_RIN) : M_WRITE;
                  default: strb_d = '0;
               endcase
            end else if (op_d >= 5'd3 && op_d <= OP_ORI) begin
               case (state_d)
                  T3: strb_d = M_GRB | M_ROUT | M_Y_IN;
                  T4: begin
                     if (op_d >= OP_ADDI) begin
                        strb_d = M_C_OUT | M_Z_IN;
                        alu_d  = (op_d == OP_ADDI) ? 5'b00011 :
                                 (op_d == OP_ANDI) ? 5'b00101 : 5'b00110;
                     end else begin
                        strb_d = M_GRC | M_ROUT | M_Z_IN;
                        alu_d  = op_d;
                     end
                  end
                  T5: strb_d = M_ZLOW_OUT | M_GRA | M_RIN;
                  default: strb_d = '0;
               endcase
            end else if (MULDIV_EN && (op_d == OP_DIV || op_d == OP_MUL)) begin
               case (state_d)
                  T3: strb_d = M_GRA | M_ROUT | M_Y_IN;
                  T4: begin
                     strb_d = M_GRB | M_ROUT | M_Z_IN;
                     alu_d  = op_d;
                  end
                  T5: strb_d = M_ZLOW_OUT | M_LO_IN;
                  T6: strb_d = M_ZHIGH_OUT | M_HI_IN;
                  default: strb_d = '0;
               endcase
            end else if (op_d == OP_BR) begin
               case (state_d)
                  T3: strb_d = M_GRA | M_ROUT | M_CON_IN;
                  T4: strb_d = M_PC_OUT | M_Y_IN;
                  T5: begin
                     strb_d = M_C_OUT | M_Z_IN;
                     alu_d  = ADD_CODE;
                  end
                  T6: strb_d = CON_out ? (M_ZLOW_OUT | M_PC_IN) : '0;
                  default: strb_d = '0;
               endcase
            end else if (op_d == OP_NEG || op_d == OP_NOT) begin
               if (state_d == T3) begin
                  strb_d = M_GRB | M_ROUT | M_Z_IN;
                  alu_d  = op_d;
               end else if (state_d == T4) begin
                  strb_d = M_ZLOW_OUT | M_GRA | M_RIN;
               end
            end else if (op_d == OP_JAL) begin
               if (state_d == T3) begin
                  strb_d = M_PC_OUT;
                  rx_d   = 16'h8000;
               end else if (state_d == T4) begin
                  strb_d = M_GRA | M_ROUT | M_PC_IN;
               end
            end else if (state_d == T3) begin
               case (op_d)
                  OP_JR:   strb_d = M_GRA | M_ROUT | M_PC_IN;
                  OP_IN:   strb_d = M_INPORT_OUT | M_GRA | M_RIN;
                  OP_OUT:  strb_d = M_GRA | M_ROUT | M_OUTPORT_IN;
                  OP_MFHI: strb_d = M_HI_OUT | M_GRA | M_RIN;
                  OP_MFLO: strb_d = M_LO_OUT | M_GRA | M_RIN;
                  default: strb_d = '0;
               endcase
            end
         end
         default: strb_d = '0;
      endcase
   end

   // State, latched opcode and registered outputs; clr forces everything to zero at once
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= RESET;
         op_q    <= '0;
         strb_q  <= '0;
         alu_q   <= '0;
         rx_q    <= '0;
         run_q   <= 1'b0;
      end else begin
         if (state_q == T2)
            assert (int'(T3) - int'(T0) == FETCH_STEPS);
         state_q <= state_d;
         op_q    <= op_d;
         strb_q  <= strb_d;
         alu_q   <= alu_d;
         rx_q    <= rx_d;
         run_q   <= run_d;
      end
   end

   assign {BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, C_out, InPort_out, MDR_out,
           LO_out, HI_out, Zlow_out, Zhigh_out, PC_out, CON_in, IncPC, OutPort_in,
           MDR_in, MAR_in, LO_in, HI_in, Z_in, Y_in, IR_in, PC_in} = strb_q;
   assign alu_instruction_bits = alu_q;
   assign RX_in_man            = rx_q;
   assign Run                  = run_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for the Mini SRC control sequencer.
module tb_control_unit;

   localparam logic [26:0] PCI = 27'd1 << 0,  IRI = 27'd1 << 1,  YI = 27'd1 << 2;
   localparam logic [26:0] ZI = 27'd1 << 3,   HII = 27'd1 << 4,  LOI = 27'd1 << 5;
   localparam logic [26:0] MARI = 27'd1 << 6, MDRI = 27'd1 << 7, OPI = 27'd1 << 8;
   localparam logic [26:0] INC = 27'd1 << 9,  CONI = 27'd1 << 10, PCO = 27'd1 << 11;
   localparam logic [26:0] ZHO = 27'd1 << 12, ZLO = 27'd1 << 13, HIO = 27'd1 << 14;
   localparam logic [26:0] LOO = 27'd1 << 15, MDRO = 27'd1 << 16, IPO = 27'd1 << 17;
   localparam logic [26:0] CO = 27'd1 << 18,  RD = 27'd1 << 19,  WR = 27'd1 << 20;
   localparam logic [26:0] GRA = 27'd1 << 21, GRB = 27'd1 << 22, GRC = 27'd1 << 23;
   localparam logic [26:0] RIN = 27'd1 << 24, ROUT = 27'd1 << 25, BAO = 27'd1 << 26;
   localparam logic [26:0] NONE = 27'd0;

   typedef struct {
      string       tag;
      logic [26:0] strb;
      logic [4:0]  alu;
      logic [15:0] rx;
      logic        run;
   } exp_t;

   logic        clk, clr, CON_out, Stop;
   logic [31:0] IR_Data;
   logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, CON_in;
   logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
   logic        Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Run;
   logic [4:0]  alu_instruction_bits;
   logic [15:0] RX_in_man;
   logic [26:0] obs_strb;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   control_unit dut (
      .clk(clk), .clr(clr), .IR_Data(IR_Data), .CON_out(CON_out), .Stop(Stop),
      .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in),
      .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in), .IncPC(IncPC), .CON_in(CON_in),
      .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out),
      .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out),
      .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .BAout(BAout), .alu_instruction_bits(alu_instruction_bits), .RX_in_man(RX_in_man),
      .Run(Run)
   );

   assign obs_strb = {BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, C_out, InPort_out, MDR_out,
                      LO_out, HI_out, Zlow_out, Zhigh_out, PC_out, CON_in, IncPC, OutPort_in,
                      MDR_in, MAR_in, LO_in, HI_in, Z_in, Y_in, IR_in, PC_in};

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic pushExp(input string tag, input logic [26:0] s, input logic [4:0] a,
                          input logic [15:0] r, input logic run);
      exp_t e;
      e.tag = tag; e.strb = s; e.alu = a; e.rx = r; e.run = run;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("[TB] FAIL scoreboard: observed=empty required=entry");
         return;
      end
      e = sb.pop_front();
      total++;
      assert (obs_strb === e.strb) else begin
         bad++; $error("[TB] FAIL %s strobes observed=%h required=%h", e.tag, obs_strb, e.strb);
      end
      total++;
      assert (alu_instruction_bits === e.alu) else begin
         bad++; $error("[TB] FAIL %s alu observed=%b required=%b", e.tag, alu_instruction_bits, e.alu);
      end
      total++;
      assert (RX_in_man === e.rx) else begin
         bad++; $error("[TB] FAIL %s rx observed=%h required=%h", e.tag, RX_in_man, e.rx);
      end
      total++;
      assert (Run === e.run) else begin
         bad++; $error("[TB] FAIL %s run observed=%b required=%b", e.tag, Run, e.run);
      end
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         checkOutput();
      end
   endtask

   // Drive a new instruction word and queue the three fetch steps it will see
   task automatic applyStimulus(input logic [31:0] ir, input logic con, input string name);
      IR_Data = ir;
      CON_out = con;
      pushExp({name, "_T0"}, PCO | MARI | INC | ZI, 5'd0, 16'h0, 1'b1);
      pushExp({name, "_T1"}, ZLO | PCI | RD | MDRI, 5'd0, 16'h0, 1'b1);
      pushExp({name, "_T2"}, MDRO | IRI, 5'd0, 16'h0, 1'b1);
   endtask

   // Pulse clr low between edges and check the immediate clear
   task automatic doReset(input string name);
      #2 clr = 1'b0;
      #1 pushExp(name, NONE, 5'd0, 16'h0, 1'b0);
      checkOutput();
      #2 clr = 1'b1;
   endtask

   initial begin
      clr = 1'b0; Stop = 1'b0; CON_out = 1'b0; IR_Data = 32'h0;
      @(posedge clk);
      #1;
      doReset("reset");

      applyStimulus(32'h69180025, 1'b0, "andi");
      pushExp("andi_T3", GRB | ROUT | YI, 5'd0, 16'h0, 1'b1);
      pushExp("andi_T4", CO | ZI, 5'b00101, 16'h0, 1'b1);
      pushExp("andi_T5", ZLO | GRA | RIN, 5'd0, 16'h0, 1'b1);
      runCycles(6);

      applyStimulus(32'h00800055, 1'b0, "ld");
      pushExp("ld_T3", GRB | BAO | YI, 5'd0, 16'h0, 1'b1);
      pushExp("ld_T4", CO | ZI, 5'b00011, 16'h0, 1'b1);
      pushExp("ld_T5", ZLO | MARI, 5'd0, 16'h0, 1'b1);
      pushExp("ld_T6", RD | MDRI, 5'd0, 16'h0, 1'b1);
      pushExp("ld_T7", MDRO | GRA | RIN, 5'd0, 16'h0, 1'b1);
      runCycles(8);

      applyStimulus(32'h10000000, 1'b0, "st");
      pushExp("st_T3", GRB | BAO | YI, 5'd0, 16'h0, 1'b1);
      pushExp("st_T4", CO | ZI, 5'b00011, 16'h0, 1'b1);
      pushExp("st_T5", ZLO | MARI, 5'd0, 16'h0, 1'b1);
      pushExp("st_T6", GRA | ROUT | MDRI, 5'd0, 16'h0, 1'b1);
      pushExp("st_T7", WR, 5'd0, 16'h0, 1'b1);
      runCycles(8);

      for (int c = 0; c < 2; c++) begin
         applyStimulus(32'h98000000, c[0], c[0] ? "br1" : "br0");
         pushExp("br_T3", GRA | ROUT | CONI, 5'd0, 16'h0, 1'b1);
         pushExp("br_T4", PCO | YI, 5'd0, 16'h0, 1'b1);
         pushExp("br_T5", CO | ZI, 5'b00011, 16'h0, 1'b1);
         pushExp(c[0] ? "br1_T6" : "br0_T6", c[0] ? (ZLO | PCI) : NONE, 5'd0, 16'h0, 1'b1);
         runCycles(7);
      end

      applyStimulus(32'h88000000, 1'b0, "neg");
      pushExp("neg_T3", GRB | ROUT | ZI, 5'd17, 16'h0, 1'b1);
      pushExp("neg_T4", ZLO | GRA | RIN, 5'd0, 16'h0, 1'b1);
      runCycles(5);

      applyStimulus(32'hA8000000, 1'b0, "jal");
      pushExp("jal_T3", PCO, 5'd0, 16'h8000, 1'b1);
      pushExp("jal_T4", GRA | ROUT | PCI, 5'd0, 16'h0, 1'b1);
      runCycles(5);

      applyStimulus(32'hC0000000, 1'b0, "mfhi");
      pushExp("mfhi_T3", HIO | GRA | RIN, 5'd0, 16'h0, 1'b1);
      runCycles(4);

      applyStimulus(32'hB0000000, 1'b0, "in");
      pushExp("in_T3", IPO | GRA | RIN, 5'd0, 16'h0, 1'b1);
      runCycles(4);

      applyStimulus(32'h70000000, 1'b0, "ori");
      pushExp("ori_T3", GRB | ROUT | YI, 5'd0, 16'h0, 1'b1);
      pushExp("ori_T4", CO | ZI, 5'b00110, 16'h0, 1'b1);
      pushExp("ori_T5", ZLO | GRA | RIN, 5'd0, 16'h0, 1'b1);
      runCycles(6);

      applyStimulus(32'h80000000, 1'b0, "mul");
`ifdef CU_MULDIV_EN
      pushExp("mul_T3", GRA | ROUT | YI, 5'd0, 16'h0, 1'b1);
      pushExp("mul_T4", GRB | ROUT | ZI, 5'd16, 16'h0, 1'b1);
      pushExp("mul_T5", ZLO | LOI, 5'd0, 16'h0, 1'b1);
      pushExp("mul_T6", ZHO | HII, 5'd0, 16'h0, 1'b1);
      runCycles(7);
`else
      pushExp("mul_T3", NONE, 5'd0, 16'h0, 1'b1);
      runCycles(4);
`endif

      applyStimulus(32'hF0000000, 1'b0, "undef");
      pushExp("undef_T3", NONE, 5'd0, 16'h0, 1'b1);
      runCycles(4);

      applyStimulus(32'h18000000, 1'b0, "add");
      pushExp("add_T3", GRB | ROUT | YI, 5'd0, 16'h0, 1'b1);
      pushExp("add_T4", GRC | ROUT | ZI, 5'b00011, 16'h0, 1'b1);
      runCycles(5);
      doReset("clr_mid_add");

      applyStimulus(32'hD0000000, 1'b0, "nop");
      pushExp("nop_T3", NONE, 5'd0, 16'h0, 1'b1);
      runCycles(4);
      Stop = 1'b1;
      pushExp("stop_halt", NONE, 5'd0, 16'h0, 1'b0);
      runCycles(1);
      Stop = 1'b0;
      pushExp("stop_hold0", NONE, 5'd0, 16'h0, 1'b0);
      pushExp("stop_hold1", NONE, 5'd0, 16'h0, 1'b0);
      runCycles(2);
      doReset("reset_after_stop");

      applyStimulus(32'hD8000000, 1'b0, "halt");
      pushExp("halt_T3", NONE, 5'd0, 16'h0, 1'b1);
      pushExp("halt_enter", NONE, 5'd0, 16'h0, 1'b0);
      for (int i = 0; i < 10; i++)
         pushExp("halt_hold", NONE, 5'd0, 16'h0, 1'b0);
      runCycles(15);
      doReset("reset_after_halt");

      applyStimulus(32'hC8000000, 1'b0, "mflo");
      pushExp("mflo_T3", LOO | GRA | RIN, 5'd0, 16'h0, 1'b1);
      runCycles(4);

      total++;
      assert (sb.size() === 0) else begin
         bad++; $error("[TB] FAIL scoreboard_drain observed=%0d required=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
